// File: rtl/ysyx_22040759_ifq.sv
// Instruction fetch queue between the fetch and decode stages.
// Circular buffer with optional empty-queue pass-through.
module ysyx_22040759_ifq #(
  parameter int DEPTH  = 4,
  parameter int PC_W   = 64,
  parameter int INST_W = 32,
  parameter int BYPASS = 1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         fs_to_q_valid,
  input  logic [PC_W+INST_W-1:0]       fs_to_q_bus,
  output logic                         q_allowin,
  output logic                         q_to_ds_valid,
  output logic [PC_W+INST_W-1:0]       q_to_ds_bus,
  input  logic                         ds_allowin,
  input  logic                         flush,
  output logic [$clog2(DEPTH+1)-1:0]   q_count
);

  localparam int BUS_W = PC_W + INST_W;
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  if (DEPTH < 2 || DEPTH > 16 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("ysyx_22040759_ifq: DEPTH must be a power of two in 2..16");
  end

  logic [BUS_W-1:0] mem_q [DEPTH];

  logic [PTR_W-1:0] head_q, head_d;
  logic [PTR_W-1:0] tail_q, tail_d;
  logic [CNT_W-1:0] cnt_q,  cnt_d;

  logic empty;
  logic full;
  logic byp_mode;
  logic push;
  logic pop;
  logic byp_take;
  logic wr_en;
  logic rd_en;

  assign empty    = (cnt_q == '0);
  assign full     = (cnt_q == FULL_CNT);
  assign byp_mode = (BYPASS != 0) & empty;
  assign q_count  = cnt_q;

  // Output side: pass-through when empty in bypass mode, else the head entry.
  always_comb begin
    q_allowin     = ~full;
    q_to_ds_valid = 1'b0;
    q_to_ds_bus   = '0;
    if (byp_mode) begin
      q_to_ds_valid = fs_to_q_valid & ~flush;
      if (q_to_ds_valid) begin
        q_to_ds_bus = fs_to_q_bus;
      end
    end else begin
      q_to_ds_valid = ~empty & ~flush;
      if (!empty) begin
        q_to_ds_bus = mem_q[head_q];
      end
    end
  end

  // Handshake qualification; a bypassed entry never touches storage.
  always_comb begin
    push     = fs_to_q_valid & q_allowin & ~flush;
    pop      = q_to_ds_valid & ds_allowin & ~flush;
    byp_take = byp_mode & push & ds_allowin;
    wr_en    = push & ~byp_take;
    rd_en    = pop & ~empty;
  end

  // Next-state for pointers and occupancy; flush wins over push and pop.
  always_comb begin
    head_d = head_q;
    tail_d = tail_q;
    cnt_d  = cnt_q;
    if (flush) begin
      head_d = '0;
      tail_d = '0;
      cnt_d  = '0;
    end else begin
      if (wr_en) begin
        tail_d = tail_q + 1'b1;
      end
      if (rd_en) begin
        head_d = head_q + 1'b1;
      end
      if (wr_en && !rd_en) begin
        cnt_d = cnt_q + 1'b1;
      end else if (rd_en && !wr_en) begin
        cnt_d = cnt_q - 1'b1;
      end
    end
  end

  // Pointer and count registers, cleared immediately on reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head_q <= '0;
      tail_q <= '0;
      cnt_q  <= '0;
    end else begin
      head_q <= head_d;
      tail_q <= tail_d;
      cnt_q  <= cnt_d;
    end
  end

  // Storage array; contents are only observed after being written.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[tail_q] <= fs_to_q_bus;
    end
  end

endmodule

// File: tb/tb_ysyx_22040759_ifq.sv
// Bench for ysyx_22040759_ifq: two instances (BYPASS=0 and 1) run side by side
// against a queue-based reference model.
module tb_ysyx_22040759_ifq;

  localparam int PW = 64;
  localparam int IW = 32;
  localparam int BW = PW + IW;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [1:0]         fv;
  logic [1:0][BW-1:0] fbus;
  logic               dsa;
  logic               flush;
  logic [1:0]         allow;
  logic [1:0]         qv;
  logic [1:0][BW-1:0] qbus;
  logic [1:0][2:0]    qcnt;

  ysyx_22040759_ifq #(
    .DEPTH(4), .PC_W(PW), .INST_W(IW), .BYPASS(0)
  ) u0 (
    .clk(clk), .rst(rst),
    .fs_to_q_valid(fv[0]), .fs_to_q_bus(fbus[0]),
    .q_allowin(allow[0]), .q_to_ds_valid(qv[0]),
    .q_to_ds_bus(qbus[0]), .ds_allowin(dsa),
    .flush(flush), .q_count(qcnt[0])
  );

  ysyx_22040759_ifq #(
    .DEPTH(4), .PC_W(PW), .INST_W(IW), .BYPASS(1)
  ) u1 (
    .clk(clk), .rst(rst),
    .fs_to_q_valid(fv[1]), .fs_to_q_bus(fbus[1]),
    .q_allowin(allow[1]), .q_to_ds_valid(qv[1]),
    .q_to_ds_bus(qbus[1]), .ds_allowin(dsa),
    .flush(flush), .q_count(qcnt[1])
  );

  logic [BW-1:0] sb [2][$];
  int checks = 0;
  int fails  = 0;

  function automatic logic [BW-1:0] mk(input logic [63:0] pc);
    logic [31:0] lo;
    lo = pc[31:0];
    return {pc, lo ^ 32'h0000_0013};
  endfunction

  task automatic ck(input string tag, input logic [127:0] obs,
                    input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic rchk(input string tag);
    for (int i = 0; i < 2; i++) begin
      ck({tag, "_cnt"},   128'(qcnt[i]),  128'(0));
      ck({tag, "_allow"}, 128'(allow[i]), 128'(1));
      ck({tag, "_valid"}, 128'(qv[i]),    128'(0));
      ck({tag, "_bus"},   128'(qbus[i]),  128'(0));
    end
  endtask

  task automatic step(input logic [1:0] v, input logic [BW-1:0] b0,
                      input logic [BW-1:0] b1, input logic d,
                      input logic f, output logic [1:0] acc);
    int  n;
    bit  byp;
    bit  e_allow;
    bit  e_v;
    bit  psh;
    bit  pp;
    logic [BW-1:0] e_bus;
    @(posedge clk);
    #1;
    fv = v; fbus[0] = b0; fbus[1] = b1; dsa = d; flush = f;
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      n       = sb[i].size();
      byp     = (i == 1) && (n == 0);
      e_allow = (n != 4);
      if (byp) begin
        e_v   = v[i] & ~f;
        e_bus = e_v ? fbus[i] : '0;
      end else begin
        e_v   = (n != 0) & ~f;
        e_bus = (n != 0) ? sb[i][0] : '0;
      end
      ck($sformatf("u%0d_cnt", i),   128'(qcnt[i]),  128'(n));
      ck($sformatf("u%0d_allow", i), 128'(allow[i]), 128'(e_allow));
      ck($sformatf("u%0d_valid", i), 128'(qv[i]),    128'(e_v));
      if (e_v || n == 0) begin
        ck($sformatf("u%0d_bus", i), 128'(qbus[i]), 128'(e_bus));
      end
      psh    = v[i] & e_allow & ~f;
      pp     = e_v & d;
      acc[i] = psh;
      if (f) begin
        sb[i].delete();
      end else if (!(byp && psh && d)) begin
        if (pp) void'(sb[i].pop_front());
        if (psh) sb[i].push_back(fbus[i]);
      end
    end
  endtask

  initial begin
    logic [1:0] acc;
    int n0;
    int n1;
    int cyc;
    rst = 1'b1; fv = '0; fbus = '0; dsa = 1'b0; flush = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rchk("reset");
    rst = 1'b0;

    // fill to DEPTH with decode stalled, then a rejected fifth push
    for (int k = 0; k < 4; k++) begin
      step(2'b11, mk(64'h8000_0000 + 64'(4 * k)),
           mk(64'h8000_0000 + 64'(4 * k)), 1'b0, 1'b0, acc);
    end
    step(2'b11, mk(64'h8000_0010), mk(64'h8000_0010), 1'b0, 1'b0, acc);

    // drain in order, then observe empty
    for (int k = 0; k < 5; k++) begin
      step(2'b00, '0, '0, 1'b1, 1'b0, acc);
    end

    // same-cycle bypass on u1, registered path on u0
    step(2'b11, mk(64'h8000_0010), mk(64'h8000_0010), 1'b1, 1'b0, acc);
    step(2'b00, '0, '0, 1'b1, 1'b0, acc);
    step(2'b00, '0, '0, 1'b0, 1'b0, acc);

    // flush with a concurrent push and ready decode
    for (int k = 0; k < 3; k++) begin
      step(2'b11, mk(64'h8000_0100 + 64'(4 * k)),
           mk(64'h8000_0100 + 64'(4 * k)), 1'b0, 1'b0, acc);
    end
    step(2'b11, mk(64'h8000_0200), mk(64'h8000_0200), 1'b1, 1'b1, acc);
    step(2'b00, '0, '0, 1'b1, 1'b0, acc);

    // stream 10 entries through with toggling decode ready
    n0 = 0; n1 = 0; cyc = 0;
    while ((n0 < 10 || n1 < 10 || sb[0].size() != 0 || sb[1].size() != 0)
           && cyc < 60) begin
      step({n1 < 10, n0 < 10},
           (n0 < 10) ? mk(64'h8000_1000 + 64'(4 * n0)) : '0,
           (n1 < 10) ? mk(64'h8000_1000 + 64'(4 * n1)) : '0,
           (cyc % 2) == 0, 1'b0, acc);
      n0 += int'(acc[0]);
      n1 += int'(acc[1]);
      cyc++;
    end
    ck("wrap_done", 128'(cyc < 60), 128'(1));
    ck("wrap_n0", 128'(n0), 128'(10));
    ck("wrap_n1", 128'(n1), 128'(10));
    step(2'b00, '0, '0, 1'b0, 1'b0, acc);

    // reset asserted between edges with two entries stored
    step(2'b11, mk(64'h8000_2000), mk(64'h8000_2000), 1'b0, 1'b0, acc);
    step(2'b11, mk(64'h8000_2004), mk(64'h8000_2004), 1'b0, 1'b0, acc);
    @(posedge clk);
    #2;
    fv = '0;
    rst = 1'b1;
    #1;
    rchk("midrst");
    sb[0].delete();
    sb[1].delete();
    @(posedge clk);
    #1;
    rst = 1'b0;
    step(2'b00, '0, '0, 1'b1, 1'b0, acc);
    step(2'b11, mk(64'h8000_3000), mk(64'h8000_3000), 1'b0, 1'b0, acc);
    step(2'b00, '0, '0, 1'b1, 1'b0, acc);
    step(2'b00, '0, '0, 1'b0, 1'b0, acc);

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule

// File: doc/ysyx_22040759_ifq.md
YSYX_22040759_IFQ -- requirements
Module: ysyx_22040759_ifq

Interface
REQ-001 SHALL provide parameter DEPTH, default 4; queue entry count; power of two; legal range 2..16.
REQ-002 SHALL provide parameter PC_W, default 64; PC field width.
REQ-003 SHALL provide parameter INST_W, default 32; instruction field width.
REQ-004 SHALL provide parameter BYPASS, default 1; 1 = empty-queue pass-through, 0 = registered-only output.
REQ-005 SHALL have ports, in order: clk  in  1  sole clock, rising edge; rst  in  1  reset, asynchronous, active-high.
REQ-006 SHALL have port fs_to_q_valid  in  1  fetch stage presents an entry.
REQ-007 SHALL have port fs_to_q_bus  in  PC_W+INST_W  {pc, inst}, with pc in the MSBs.
REQ-008 SHALL have port q_allowin  out  1  queue accepts an entry this cycle.
REQ-009 SHALL have port q_to_ds_valid  out  1  head entry valid to decode.
REQ-010 SHALL have port q_to_ds_bus  out  PC_W+INST_W  head entry, same packing as fs_to_q_bus.
REQ-011 SHALL have port ds_allowin  in  1  decode accepts the head this cycle.
REQ-012 SHALL have port flush  in  1  branch redirect; discards all contents.
REQ-013 SHALL have port q_count  out  $clog2(DEPTH+1)  number of stored entries.

Function
REQ-014 SHALL maintain a circular buffer of DEPTH entries with head pointer, tail pointer and count registers; pointers SHALL be log2(DEPTH) wide and wrap naturally modulo DEPTH.
REQ-015 SHALL drive q_allowin = (q_count != DEPTH); a pop in the same cycle SHALL NOT free space for a push when full.
REQ-016 SHALL define push = fs_to_q_valid & q_allowin & ~flush.
REQ-017 SHALL define pop = q_to_ds_valid & ds_allowin & ~flush.
REQ-018 SHALL, on push, write fs_to_q_bus at the tail and advance the tail at the next edge, except in the bypass case of REQ-021.
REQ-019 SHALL, on pop, advance the head at the next edge.
REQ-020 SHALL update the count as +1 on push only, -1 on pop only, and unchanged on simultaneous push and pop.
REQ-021 SHALL, with BYPASS=1 and count==0, drive q_to_ds_valid = fs_to_q_valid & ~flush and q_to_ds_bus = fs_to_q_bus combinationally; if ds_allowin=1 the entry SHALL be consumed with no write and no pointer or count change.
REQ-022 SHALL, with BYPASS=0 or count!=0, drive q_to_ds_valid = (count!=0) & ~flush and q_to_ds_bus = entry at the head; latency from push to head visibility SHALL be 1 cycle when empty.
REQ-023 SHALL, when flush=1, force q_to_ds_valid=0 in that cycle and set head, tail and count to 0 at the next edge; flush SHALL take priority over simultaneous push and pop.
REQ-024 SHALL keep q_to_ds_bus stable while q_to_ds_valid=1 and ds_allowin=0.
REQ-025 SHALL preserve FIFO order across pointer wrap-around.
REQ-026 SHALL never overflow or underflow; push when full and pop when empty SHALL be impossible by construction.
REQ-027 SHALL drive q_to_ds_bus = 0 when q_to_ds_valid=0 and the queue is empty, to keep waveforms deterministic.

Reset
REQ-028 SHALL, on rst=1 at any time including mid-transfer, immediately clear head, tail and count; outputs SHALL then be q_count=0, q_allowin=1, q_to_ds_valid=0 (given ~fs_to_q_valid, or BYPASS=0), and q_to_ds_bus=0.
REQ-029 SHALL NOT require reset of the storage array; contents are unobservable until written.
REQ-030 SHALL release reset synchronously to clk in the integrating testbench; the block itself SHALL NOT depend on release timing.

Verification
REQ-031 SHALL be verified by filling: DEPTH=4, BYPASS=0, ds_allowin=0, push pc 0x80000000..0x8000000C -> q_count=4, q_allowin=0; a fifth push is ignored.
REQ-032 SHALL be verified by draining: from the full state, ds_allowin=1 -> heads 0x80000000, 0x80000004, 0x80000008, 0x8000000C on 4 successive cycles, then q_to_ds_valid=0 and q_count=0.
REQ-033 SHALL be verified in bypass: BYPASS=1, empty queue, push pc 0x80000010 with ds_allowin=1 -> same-cycle q_to_ds_valid=1 and bus pc=0x80000010; q_count stays 0.
REQ-034 SHALL be verified on flush: 3 entries stored, flush=1 together with fs_to_q_valid=1 -> q_to_ds_valid=0 that cycle; next cycle q_count=0 and the pushed entry is not stored.
REQ-035 SHALL be verified on wrap: 10 entries streamed with ds_allowin toggling 1,0,1,... -> output order matches input order exactly, q_count never exceeds 4.
REQ-036 SHALL be verified on reset mid-operation: 2 entries stored, rst asserted between edges -> q_count=0 and q_to_ds_valid=0 before the next edge.
